// File: rtl/video_timing_pkg.sv
// Timing constants and the per-pixel timing record shared by the video timing generator.
package video_timing_pkg;

    localparam int POS_W = 11;
    localparam int CNT_W = 12;

    // 1920x1080 @ 60 Hz (148.5 MHz)
    localparam int H1080_ACTIVE = 1920;
    localparam int H1080_FP     = 88;
    localparam int H1080_SYNC   = 44;
    localparam int H1080_BP     = 148;
    localparam int V1080_ACTIVE = 1080;
    localparam int V1080_FP     = 4;
    localparam int V1080_SYNC   = 5;
    localparam int V1080_BP     = 36;

    // 1280x720 @ 60 Hz (74.25 MHz)
    localparam int H720_ACTIVE  = 1280;
    localparam int H720_FP      = 110;
    localparam int H720_SYNC    = 40;
    localparam int H720_BP      = 220;
    localparam int V720_ACTIVE  = 720;
    localparam int V720_FP      = 5;
    localparam int V720_SYNC    = 5;
    localparam int V720_BP      = 20;

    // 640x480 @ 60 Hz (25.175 MHz)
    localparam int H480_ACTIVE  = 640;
    localparam int H480_FP      = 16;
    localparam int H480_SYNC    = 96;
    localparam int H480_BP      = 48;
    localparam int V480_ACTIVE  = 480;
    localparam int V480_FP      = 10;
    localparam int V480_SYNC    = 2;
    localparam int V480_BP      = 33;

    typedef struct packed {
        logic             hsyn;
        logic             vsyn;
        logic             de;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             frame_start;
    } timing_t;

endpackage

// File: rtl/video_timing_gen_delay.sv
// Clearable shift register; every stage loads i_rst_val on async reset or synchronous clear.
module sync_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= i_rst_val;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= i_rst_val;
        end else begin
            stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters, region decode, and an early pixel request that
// leads the registered sync/de/position outputs by REQ_LEAD cycles.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H1080_ACTIVE,
    parameter int   H_FP     = H1080_FP,
    parameter int   H_SYNC   = H1080_SYNC,
    parameter int   H_BP     = H1080_BP,
    parameter int   V_ACTIVE = V1080_ACTIVE,
    parameter int   V_FP     = V1080_FP,
    parameter int   V_SYNC   = V1080_SYNC,
    parameter int   V_BP     = V1080_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   REQ_LEAD = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_hsyn,
    output logic             o_vsyn,
    output logic             o_de,
    output logic [POS_W-1:0] o_x_pos,
    output logic [POS_W-1:0] o_y_pos,
    output logic             o_data_req,
    output logic             o_frame_start
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    localparam timing_t RST_VAL = timing_t'({~HS_POL, ~VS_POL, 1'b0,
                                             {POS_W{1'b0}}, {POS_W{1'b0}}, 1'b0});

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_act;
    logic             v_act;
    timing_t          dec;
    timing_t          stage0;
    timing_t          dl_q;

    // Counters sit at (0,0) while disabled so the first enabled cycle opens a frame in sync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!i_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_act           = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
        v_act           = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        dec             = RST_VAL;
        dec.hsyn        = (h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
        dec.vsyn        = (v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
        dec.de          = h_act && v_act;
        dec.frame_start = (h_cnt == H_ACT_BEG) && (v_cnt == V_ACT_BEG);
        if (h_act && v_act) begin
            dec.x = POS_W'(h_cnt - H_ACT_BEG);
            dec.y = POS_W'(v_cnt - V_ACT_BEG);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage0 <= RST_VAL;
        end else if (!i_en) begin
            stage0 <= RST_VAL;
        end else begin
            stage0 <= dec;
        end
    end

    // Request taps stage 0; everything else trails it by REQ_LEAD registers.
    sync_delay_line #(
        .WIDTH ($bits(timing_t)),
        .DEPTH (REQ_LEAD)
    ) u_delay (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (~i_en),
        .i_rst_val (RST_VAL),
        .i_d       (stage0),
        .o_q       (dl_q)
    );

    assign o_data_req    = stage0.de;
    assign o_hsyn        = dl_q.hsyn;
    assign o_vsyn        = dl_q.vsyn;
    assign o_de          = dl_q.de;
    assign o_x_pos       = dl_q.x;
    assign o_y_pos       = dl_q.y;
    assign o_frame_start = dl_q.frame_start;

endmodule
